// File: rtl/gated_reg_bank.sv
// ---------------------------------------------------------------------------
// gated_reg_bank : addressed register bank with registered read and preset sweep
// Optional read parity: GATED_REG_BANK_PARITY_EN.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module gated_reg_bank #(
  parameter int              WIDTH      = 4,
  parameter int              CHANNELS   = 4,
  parameter logic [WIDTH-1:0] PRESET_VAL = {WIDTH{1'b1}},
  localparam int             AW         = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [WIDTH-1:0]          d,
  input  logic [AW-1:0]             addr,
  input  logic                      g,
  input  logic                      pre,
  input  logic [AW-1:0]             raddr,
  output logic [WIDTH-1:0]          q,
  output logic [CHANNELS*WIDTH-1:0] q_all,
  output logic                      busy,
  output logic                      done,
  output logic                      perr
);

  typedef enum logic [0:0] {IDLE = 1'b0, SWEEP = 1'b1} state_t;

  localparam logic [AW-1:0] LAST_IDX = AW'(CHANNELS - 1);
  localparam logic [AW:0]   CH_LIM   = (AW + 1)'(CHANNELS);

  state_t           state_q, state_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] mem_q [CHANNELS];
  logic [WIDTH-1:0] q_q;

  logic             wr_en;
  logic [AW-1:0]    wr_idx;
  logic [WIDTH-1:0] wr_data;
  logic [WIDTH-1:0] rd_data;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    wr_en   = 1'b0;
    wr_idx  = addr;
    wr_data = d;
    case (state_q)
      IDLE: begin
        // A sweep request wins over a same-cycle write, which is dropped.
        if (pre) begin
          state_d = SWEEP;
          idx_d   = '0;
        end else if (!g && ({1'b0, addr} < CH_LIM)) begin
          wr_en = 1'b1;
        end
      end
      SWEEP: begin
        wr_en   = 1'b1;
        wr_idx  = idx_q;
        wr_data = PRESET_VAL;
        if (idx_q == LAST_IDX) begin
          state_d = IDLE;
          idx_d   = '0;
          done_d  = 1'b1;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) mem_q[i] <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (wr_en && (wr_idx == AW'(i))) mem_q[i] <= wr_data;
      end
    end
  end

  // Decoded read mux yields zero for any unpopulated address.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (raddr == AW'(i)) rd_data = mem_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= '0;
    else        q_q <= rd_data;
  end

`ifdef GATED_REG_BANK_PARITY_EN
  logic par_q [CHANNELS];
  logic rd_par;
  logic perr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) par_q[i] <= 1'b0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (wr_en && (wr_idx == AW'(i))) par_q[i] <= ^wr_data;
      end
    end
  end

  always_comb begin
    rd_par = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (raddr == AW'(i)) rd_par = par_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) perr_q <= 1'b0;
    else        perr_q <= rd_par ^ (^rd_data);
  end

  assign perr = perr_q;
`else
  assign perr = 1'b0;
`endif

  for (genvar i = 0; i < CHANNELS; i++) begin : g_qall
    assign q_all[i*WIDTH +: WIDTH] = mem_q[i];
  end

  assign q    = q_q;
  assign busy = (state_q == SWEEP);
  assign done = done_q;

endmodule

`default_nettype wire

// File: tb/tb_gated_reg_bank.sv
// Testbench for gated_reg_bank: vector table with scoreboard, plus reset/sweep/range sequences.
`default_nettype none

module tb_gated_reg_bank;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  d = '0;
  logic [1:0]  addr = '0;
  logic        g = 1'b1;
  logic        pre = 1'b0;
  logic [1:0]  raddr = '0;
  logic [3:0]  q;
  logic [15:0] q_all;
  logic        busy, done, perr;

  logic [3:0]  d3 = '0;
  logic [1:0]  addr3 = '0;
  logic        g3 = 1'b1;
  logic [1:0]  raddr3 = '0;
  logic [3:0]  q3;
  logic [11:0] q_all3;
  logic        busy3, done3, perr3;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  gated_reg_bank #(.WIDTH(4), .CHANNELS(4)) dut (
    .clk(clk), .rst_n(rst_n), .d(d), .addr(addr), .g(g), .pre(pre),
    .raddr(raddr), .q(q), .q_all(q_all), .busy(busy), .done(done), .perr(perr)
  );

  gated_reg_bank #(.WIDTH(4), .CHANNELS(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .d(d3), .addr(addr3), .g(g3), .pre(1'b0),
    .raddr(raddr3), .q(q3), .q_all(q_all3), .busy(busy3), .done(done3), .perr(perr3)
  );

  typedef struct {
    logic        g;
    logic [1:0]  addr;
    logic [3:0]  d;
    logic        pre;
    logic [1:0]  raddr;
    logic [3:0]  eq;
    logic [15:0] eqa;
    logic        eb;
    logic        ed;
  } vec_t;

  typedef struct {
    int          row;
    logic [3:0]  eq;
    logic [15:0] eqa;
    logic        eb;
    logic        ed;
  } exp_t;

  vec_t vecs[19];
  exp_t sb[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp_t e;
    logic [3:0] exp_busy;
    logic [3:0] exp_done;

    // g, addr, d, pre, raddr | q, q_all, busy, done  (values after the edge)
    vecs[0]  = '{1'b0, 2'd2, 4'h5, 1'b0, 2'd0, 4'h0, 16'h0500, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 2'd0, 4'h0, 1'b0, 2'd2, 4'h5, 16'h0500, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 2'd2, 4'hA, 1'b0, 2'd2, 4'h5, 16'h0A00, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 2'd0, 4'h0, 1'b0, 2'd2, 4'hA, 16'h0A00, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 2'd0, 4'h3, 1'b0, 2'd1, 4'h0, 16'h0A03, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 2'd3, 4'hC, 1'b0, 2'd0, 4'h3, 16'hCA03, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 2'd1, 4'h6, 1'b0, 2'd3, 4'hC, 16'hCA63, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 2'd1, 4'h3, 1'b1, 2'd1, 4'h6, 16'hCA63, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 2'd1, 4'h0, 1'b0, 2'd0, 4'h3, 16'hCA6F, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 2'd2, 4'h0, 1'b1, 2'd1, 4'h6, 16'hCAFF, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 2'd0, 4'h0, 1'b0, 2'd2, 4'hA, 16'hCFFF, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 2'd0, 4'h0, 1'b0, 2'd3, 4'hC, 16'hFFFF, 1'b0, 1'b1};
    vecs[12] = '{1'b1, 2'd0, 4'h0, 1'b1, 2'd1, 4'hF, 16'hFFFF, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 2'd0, 4'h0, 1'b0, 2'd0, 4'hF, 16'hFFFF, 1'b1, 1'b0};
    vecs[14] = '{1'b0, 2'd1, 4'h0, 1'b0, 2'd0, 4'hF, 16'hFFFF, 1'b1, 1'b0};
    vecs[15] = '{1'b1, 2'd0, 4'h0, 1'b0, 2'd0, 4'hF, 16'hFFFF, 1'b1, 1'b0};
    vecs[16] = '{1'b1, 2'd0, 4'h0, 1'b0, 2'd0, 4'hF, 16'hFFFF, 1'b0, 1'b1};
    vecs[17] = '{1'b0, 2'd1, 4'h2, 1'b0, 2'd0, 4'hF, 16'hFF2F, 1'b0, 1'b0};
    vecs[18] = '{1'b1, 2'd0, 4'h0, 1'b0, 2'd1, 4'h2, 16'hFF2F, 1'b0, 1'b0};

    // Reset state while clock runs
    repeat (2) @(negedge clk);
    chk("reset_q", 32'(q), 32'h0);
    chk("reset_q_all", 32'(q_all), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_done", 32'(done), 32'h0);
    chk("reset_perr", 32'(perr), 32'h0);
    rst_n = 1'b1;

    // Table-driven vectors through the scoreboard
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      g = vecs[i].g; addr = vecs[i].addr; d = vecs[i].d;
      pre = vecs[i].pre; raddr = vecs[i].raddr;
      sb.push_back('{i, vecs[i].eq, vecs[i].eqa, vecs[i].eb, vecs[i].ed});
      tick();
      if (sb.size() == 0) begin
        chk("scoreboard_empty", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk($sformatf("row%0d_q", e.row), 32'(q), 32'(e.eq));
        chk($sformatf("row%0d_q_all", e.row), 32'(q_all), 32'(e.eqa));
        chk($sformatf("row%0d_busy", e.row), 32'(busy), 32'(e.eb));
        chk($sformatf("row%0d_done", e.row), 32'(done), 32'(e.ed));
        chk($sformatf("row%0d_perr", e.row), 32'(perr), 32'h0);
      end
    end

    // Mid-sweep asynchronous reset after two sweep writes
    @(negedge clk); g = 1'b1; pre = 1'b1; raddr = 2'd0;
    tick();
    @(negedge clk); pre = 1'b0;
    tick();
    tick();
    chk("midsweep_pre_qall", 32'(q_all), 32'h0000FF2F & 32'h0000FFFF | 32'h0000_00FF);
    rst_n = 1'b0;
    #1;
    chk("midsweep_busy", 32'(busy), 32'h0);
    chk("midsweep_q_all", 32'(q_all), 32'h0);
    chk("midsweep_q", 32'(q), 32'h0);
    chk("midsweep_done", 32'(done), 32'h0);

    // Post-release sweep: busy for exactly 4 cycles, then one done cycle
    @(negedge clk); rst_n = 1'b1; pre = 1'b1;
    tick();
    chk("post_sweep_busy0", 32'(busy), 32'h1);
    @(negedge clk); pre = 1'b0;
    exp_busy = 4'b0111;
    exp_done = 4'b1000;
    for (int j = 0; j < 4; j++) begin
      tick();
      chk($sformatf("post_sweep_busy%0d", j + 1), 32'(busy), 32'(exp_busy[j]));
      chk($sformatf("post_sweep_done%0d", j + 1), 32'(done), 32'(exp_done[j]));
    end
    chk("post_sweep_q_all", 32'(q_all), 32'hFFFF);
    tick();
    chk("post_sweep_done_end", 32'(done), 32'h0);
    @(negedge clk); raddr = 2'd3;
    tick();
    chk("post_sweep_q", 32'(q), 32'hF);
    chk("post_sweep_perr", 32'(perr), 32'h0);

    // Out-of-range addresses on a 3-channel bank
    @(negedge clk); g3 = 1'b0; addr3 = 2'd3; d3 = 4'h5; raddr3 = 2'd3;
    tick();
    chk("oor_write_q_all", 32'(q_all3), 32'h000);
    @(negedge clk); addr3 = 2'd2; d3 = 4'h9;
    tick();
    chk("inrange_write_q_all", 32'(q_all3), 32'h900);
    @(negedge clk); g3 = 1'b1; raddr3 = 2'd3;
    tick();
    chk("oor_read_q", 32'(q3), 32'h0);
    @(negedge clk); raddr3 = 2'd2;
    tick();
    chk("inrange_read_q", 32'(q3), 32'h9);
    chk("oor_perr", 32'(perr3), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/gated_reg_bank.md
# gated_reg_bank

Parametrised multi-channel storage bank, next generation of the team's 4-bit preset/gated latch. Replaces the level-sensitive latch with edge-triggered registers on one clock. Adds addressed channels, a registered read port, and a sequenced preset sweep with busy/done handshake. Sits between configuration writers and datapath consumers that need a bulk "all ones" restore.

## Interface

Parameters:
- `WIDTH`, 4, data bits per channel.
- `CHANNELS`, 4, number of channels; must be ≥2.
- `PRESET_VAL`, `{WIDTH{1'b1}}`, value written to every channel by a sweep.
- `AW`, `$clog2(CHANNELS)`, localparam; address width.

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `d`  in  WIDTH  write data.
- `addr`  in  AW  write channel select.
- `g`  in  1  write gate, active-low; write occurs when `g==0`.
- `pre`  in  1  preset-sweep request, active-high, sampled on the edge.
- `raddr`  in  AW  read channel select.
- `q`  out  WIDTH  registered read data.
- `q_all`  out  CHANNELS*WIDTH  all channels, combinational from storage; channel 0 in the LSBs.
- `busy`  out  1  sweep in progress.
- `done`  out  1  one-cycle pulse at sweep end.
- `perr`  out  1  registered read parity error (see Configuration).

## Operation

- Reset (`rst_n` low): every channel = 0; `q`=0; `busy`=0; `done`=0; `perr`=0; FSM=IDLE; sweep index=0. Takes effect immediately and regardless of clock, including mid-sweep.
- FSM states: IDLE, SWEEP.
- IDLE, `pre`=1: go to SWEEP with index 0. Any write request in the same cycle is dropped. `pre` has priority over `g`, as in the previous generation.
- IDLE, `pre`=0, `g`=0, `addr`<CHANNELS: channel[`addr`] <= `d`.
- Write with `addr`≥CHANNELS: ignored.
- SWEEP, each edge: channel[index] <= PRESET_VAL, index++.
  - After the edge that writes channel CHANNELS-1, go to IDLE and index returns to 0.
  - `pre` and `g` are both ignored throughout SWEEP; writes are dropped, not queued.
- Read, every edge: `q` <= channel[`raddr`] when `raddr`<CHANNELS, else 0. Read-during-write to the same channel returns the old value.
- `q_all` reflects storage contents after each edge.

## Timing

- Write latency: data visible on `q_all` after the write edge. Visible on `q` one edge later, with `raddr` held.
- Read latency: 1 cycle from `raddr` to `q`.
- Sweep, with `pre` sampled at edge k:
  - `busy`=1 from after edge k to after edge k+CHANNELS, i.e. CHANNELS cycles.
  - Channel i is written at edge k+1+i.
  - `done`=1 for exactly the cycle after edge k+CHANNELS. `busy` is 0 in that cycle.
- Back-to-back: `pre` held high in the `done` cycle starts a new sweep at that edge.
- `rst_n` deassertion is taken synchronously to `clk` externally. The first sweep may be requested on the first edge after release.

## Configuration

- `GATED_REG_BANK_PARITY_EN` defined:
  - Each channel stores an extra even-parity bit, computed on every write and sweep write. Reset parity = 0.
  - On each read edge, `perr` <= (stored parity != ^stored data) for valid `raddr`, else 0.
- Not defined: no parity storage; `perr` tied 0. The port is always present.

## Test plan

- Reset check, with WIDTH=4, CHANNELS=4: assert `rst_n`=0 → `q`=0, `q_all`=16'h0000, `busy`=0, `done`=0, `perr`=0.
- Write/read: `g`=0, `addr`=2, `d`=4'b0101 for one edge; then `raddr`=2 → `q`=4'b0101 one edge later, `q_all`=16'h0500. A write with `addr` out of range leaves `q_all` unchanged.
- Sweep: pulse `pre` for one edge → `busy` high exactly 4 cycles; `done` high 1 cycle after; `q_all`=16'hFFFF.
- Collision: `pre`=1 with `g`=0, `addr`=1, `d`=4'b0011 on the same edge; also `g`=0 writes during `busy` → all dropped, channel 1 = 4'b1111 after the sweep.
- Mid-sweep reset: drop `rst_n` after 2 sweep writes → `busy`=0, `q_all`=0 immediately. A post-release `pre` runs a full 4-cycle sweep.
- Parity, with the macro defined: write 4'b0111 to channel 3 and read it back → `q`=4'b0111, `perr`=0. Reads of all channels after reset and after a sweep → `perr`=0.
